// File: rtl/csa_accum.sv
// csa_accum: streaming multi-operand accumulator on a 3:2 carry-save pair.
// Define CSA_ACCUM_FAST_RESOLVE_EN for a one-cycle carry-propagate resolve.
module csa_accum #(
  parameter int BITS     = 8,
  parameter int ACC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_sum,
  output logic                out_ovf
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ACC_BITS-1:0] s_reg, s_next;
  logic [ACC_BITS-1:0] c_reg, c_next;
  logic [ACC_BITS-1:0] out_sum_reg, out_sum_next;
  logic                ovf_reg, ovf_next;
  logic                out_ovf_reg, out_ovf_next;
  logic                out_valid_reg, out_valid_next;

  logic [ACC_BITS-1:0] x;
  logic [ACC_BITS-1:0] csa_sum;
  logic [ACC_BITS-1:0] csa_maj;
  logic                accept;
  logic                out_fire;
  logic                resolve_done;

  assign x        = ACC_BITS'(in_data);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_BITS; gi++) begin : g_csa
      assign csa_sum[gi] = s_reg[gi] ^ c_reg[gi] ^ x[gi];
      assign csa_maj[gi] = (s_reg[gi] & c_reg[gi]) | (s_reg[gi] & x[gi]) | (c_reg[gi] & x[gi]);
    end
  endgenerate

`ifdef CSA_ACCUM_FAST_RESOLVE_EN
  logic [ACC_BITS:0] wide_sum;
  assign wide_sum     = {1'b0, s_reg} + {1'b0, c_reg};
  assign resolve_done = 1'b1;
`else
  // Half-adder sweep: each pass pushes every pending carry one bit left.
  logic [ACC_BITS-1:0] ha_carry;
  generate
    for (gi = 0; gi < ACC_BITS; gi++) begin : g_ha
      assign ha_carry[gi] = s_reg[gi] & c_reg[gi];
    end
  endgenerate
  assign resolve_done = (c_reg == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && in_last) state_next = RESOLVE;
      RESOLVE: if (resolve_done)      state_next = DONE;
      DONE:    if (out_fire)          state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == ACCUM);
  end

  always_comb begin
    s_next         = s_reg;
    c_next         = c_reg;
    ovf_next       = ovf_reg;
    out_sum_next   = out_sum_reg;
    out_ovf_next   = out_ovf_reg;
    // Result becomes visible the cycle after DONE is entered and drops on handshake.
    out_valid_next = (state_reg == DONE) && !out_fire;
    case (state_reg)
      ACCUM: begin
        if (accept) begin
          s_next   = csa_sum;
          c_next   = csa_maj << 1;
          ovf_next = ovf_reg | csa_maj[ACC_BITS-1];
        end
      end
      RESOLVE: begin
`ifdef CSA_ACCUM_FAST_RESOLVE_EN
        out_sum_next = wide_sum[ACC_BITS-1:0];
        out_ovf_next = ovf_reg | wide_sum[ACC_BITS];
`else
        if (resolve_done) begin
          out_sum_next = s_reg;
          out_ovf_next = ovf_reg;
        end else begin
          s_next   = s_reg ^ c_reg;
          c_next   = ha_carry << 1;
          ovf_next = ovf_reg | ha_carry[ACC_BITS-1];
        end
`endif
      end
      DONE: begin
        if (out_fire) begin
          s_next   = '0;
          c_next   = '0;
          ovf_next = 1'b0;
        end
      end
      default: begin
        s_next   = '0;
        c_next   = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg         <= '0;
      c_reg         <= '0;
      ovf_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      s_reg         <= s_next;
      c_reg         <= c_next;
      ovf_reg       <= ovf_next;
      out_sum_reg   <= out_sum_next;
      out_ovf_reg   <= out_ovf_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_ovf   = out_ovf_reg;

endmodule
